reg_writeback: RTL and testbench
================================

Name: reg_writeback

Overview:
- Write-side sequencer for the 16 x 32 register bank.
- Collects results from the ALU path (single-cycle) and the load path (multi-cycle memory return), then serialises them into one registered write per cycle on the bank's Dest/data/enable inputs.
- Keeps a per-register pending-load scoreboard so issue logic can stall on RAW hazards.

Parameters:
- DEPTH, 4, ALU result FIFO entries (power of 2, >= 2)
- AW, 2, FIFO pointer width, log2(DEPTH)

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- alu_valid  input  1  ALU result offered
- alu_dest  input  4  ALU destination register
- alu_data  input  32  ALU result
- alu_ready  output  1  FIFO can accept; a transfer occurs when alu_valid && alu_ready
- ld_issue  input  1  a load is issued this cycle
- ld_issue_dest  input  4  destination of the issued load
- ld_valid  input  1  load data returning; always accepted, no backpressure
- ld_dest  input  4  destination of the returning load
- ld_data  input  32  returned load data
- wb_en  output  1  register bank write enable
- wb_dest  output  4  register bank Dest
- wb_data  output  32  register bank write data
- busy  output  16  scoreboard; bit n set = load pending on rn
- issue_err  output  1  sticky: load issued to an already-busy register

Behaviour:
- Reset (async): FIFO empty, pointers 0; wb_en=0, wb_dest=0, wb_data=0; busy=0; issue_err=0. alu_ready=1 once reset deasserts.
- ALU FIFO:
  - DEPTH entries of {dest, data}; alu_ready = !full.
  - Push on alu_valid && alu_ready.
  - Count is AW+1 bits; read and write pointers wrap modulo DEPTH.
- Arbitration each cycle: one write slot.
  - ld_valid has priority: wb_en=1, wb_dest=ld_dest, wb_data=ld_data on the next edge.
  - Otherwise, if FIFO is non-empty: pop the head and drive it on the next edge.
  - Otherwise: wb_en=0 next cycle; wb_dest and wb_data hold their last values.
- Latency:
  - Uncontended ALU result is written to the bank 2 edges after acceptance (push edge, then pop/register edge).
  - Load data is written 1 edge after ld_valid.
- Full-FIFO push with simultaneous pop: not allowed, because alu_ready is derived from full only. The ALU stalls for one cycle.
- Empty FIFO with push and no load in the same cycle: the entry is pushed. The pop happens the following cycle; there is no same-cycle bypass.
- Scoreboard:
  - ld_issue sets busy[ld_issue_dest] on the edge.
  - A load writeback clears busy[ld_dest] on the edge it is registered.
  - Same edge, same register, set and clear: set wins (back-to-back load).
  - Same edge, different registers: both take effect.
- issue_err is set when ld_issue && busy[ld_issue_dest] && !(ld_valid && ld_dest==ld_issue_dest). It clears only on reset.
- ld_valid to a non-busy register is still written; busy is unaffected.
- Load ordering: loads return in issue order; at most one outstanding load per register.
- Write ordering: the ALU must not produce a result for a busy register; upstream stall uses busy. Write ordering between paths is therefore not checked here.
- Reset mid-operation: FIFO contents are discarded, pending loads are forgotten, and wb_en drops immediately (async).

Optional Feature:
- Macro: WB_FWD_EN
- Defined: adds ports fwd_src (input, 4), fwd_hit (output, 1) and fwd_data (output, 32). These are combinational.
  - Match priority: first, the in-flight load (ld_valid && ld_dest==fwd_src); then the youngest matching FIFO entry; then the registered wb stage when wb_en.
  - fwd_hit=1 with the matching data; otherwise fwd_hit=0 and fwd_data=0.
- Undefined: the ports are absent and there is no forwarding logic.

Decomposition:
- Package wb_pkg:
  - REG_W=4, DATA_W=32, NREGS=16
  - typedef wb_entry_t {dest[3:0], data[31:0]}
- One sub-module: wb_fifo, a parameterised DEPTH FIFO of wb_entry_t with push/pop/full/empty/count. When WB_FWD_EN is defined, wb_fifo also exposes an entry read port for the forwarding search.

Test Plan:
- Reset, then a single ALU push (r3, 0x0000_00AA) -> wb_en=1, wb_dest=3, wb_data=0xAA exactly 2 edges later, and only for that one cycle.
- Fill the FIFO with 4 ALU results while ld_valid is held high for 6 cycles -> alu_ready=0 after the 4th push; loads are written first; the FIFO then drains in push order r1..r4.
- ld_issue r5, ld_valid r5 data 0x1234 three cycles later -> busy[5]=1 during the gap; busy[5]=0 and r5 written 0x1234 on the same edge.
- ld_issue r7 on the same edge as the returning ld_valid r7 -> busy[7] stays 1 and issue_err stays 0. A second ld_issue r7 while busy -> issue_err=1 and sticky.
- Assert reset with 3 entries queued and busy=0x0021 -> wb_en=0 immediately, busy=0, FIFO empty; no stale writes after release.
- (WB_FWD_EN) FIFO holds r2=0x10 then r2=0x20, fwd_src=2 -> fwd_hit=1, fwd_data=0x20. Same-cycle ld_valid r2=0x30 -> fwd_data=0x30.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared widths and the {dest, data} write-back entry used by the register write-back path.
package wb_pkg;

  localparam int REG_W  = 4;
  localparam int DATA_W = 32;
  localparam int NREGS  = 16;

  typedef struct packed {
    logic [REG_W-1:0]  dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/reg_writeback_if.sv
// ALU, load and bank-write signal bundle of reg_writeback; the forwarding
// signals exist only when WB_FWD_EN is defined.
interface reg_writeback_if;
  import wb_pkg::*;

  logic              alu_valid;
  logic [REG_W-1:0]  alu_dest;
  logic [DATA_W-1:0] alu_data;
  logic              alu_ready;
  logic              ld_issue;
  logic [REG_W-1:0]  ld_issue_dest;
  logic              ld_valid;
  logic [REG_W-1:0]  ld_dest;
  logic [DATA_W-1:0] ld_data;
  logic              wb_en;
  logic [REG_W-1:0]  wb_dest;
  logic [DATA_W-1:0] wb_data;
  logic [NREGS-1:0]  busy;
  logic              issue_err;
`ifdef WB_FWD_EN
  logic [REG_W-1:0]  fwd_src;
  logic              fwd_hit;
  logic [DATA_W-1:0] fwd_data;
`endif

`ifdef WB_FWD_EN
  modport master (
    output alu_valid, alu_dest, alu_data, ld_issue, ld_issue_dest,
           ld_valid, ld_dest, ld_data, fwd_src,
    input  alu_ready, wb_en, wb_dest, wb_data, busy, issue_err,
           fwd_hit, fwd_data
  );
  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_issue, ld_issue_dest,
           ld_valid, ld_dest, ld_data, fwd_src,
    output alu_ready, wb_en, wb_dest, wb_data, busy, issue_err,
           fwd_hit, fwd_data
  );
`else
  modport master (
    output alu_valid, alu_dest, alu_data, ld_issue, ld_issue_dest,
           ld_valid, ld_dest, ld_data,
    input  alu_ready, wb_en, wb_dest, wb_data, busy, issue_err
  );
  modport slave (
    input  alu_valid, alu_dest, alu_data, ld_issue, ld_issue_dest,
           ld_valid, ld_dest, ld_data,
    output alu_ready, wb_en, wb_dest, wb_data, busy, issue_err
  );
`endif

endinterface

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of write-back entries; with WB_FWD_EN it also searches the
// live entries for the youngest one matching a destination register.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push_i,
  input  wb_entry_t         pushEntry_i,
  input  logic              pop_i,
  output wb_entry_t         head_o,
  output logic              full_o,
  output logic              empty_o,
  output logic [AW:0]       count_o
`ifdef WB_FWD_EN
  ,
  input  logic [REG_W-1:0]  srchDest_i,
  output logic              srchHit_o,
  output logic [DATA_W-1:0] srchData_o
`endif
);

  localparam int CW = AW + 1;

  wb_entry_t         mem_q [DEPTH];
  logic [AW-1:0]     wrPtr_q;
  logic [AW-1:0]     rdPtr_q;
  logic [AW:0]       count_q;
  logic [AW:0]       count_d;
  logic              doPush;
  logic              doPop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign head_o  = mem_q[rdPtr_q];
  assign doPush  = push_i && !full_o;
  assign doPop   = pop_i && !empty_o;

  always_comb begin
    count_d = count_q;
    case ({doPush, doPop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Storage carries no reset; count alone decides which slots are live.
  always_ff @(posedge clk) begin
    if (doPush) mem_q[wrPtr_q] <= pushEntry_i;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
    end else begin
      if (doPush) wrPtr_q <= wrPtr_q + AW'(1);
      if (doPop)  rdPtr_q <= rdPtr_q + AW'(1);
      count_q <= count_d;
    end
  end

`ifdef WB_FWD_EN
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    logic [AW-1:0] idx;
    srchHit_o  = 1'b0;
    srchData_o = '0;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = rdPtr_q + AW'(i);
      if ((CW'(i) < count_q) && (mem_q[idx].dest == srchDest_i)) begin
        srchHit_o  = 1'b1;
        srchData_o = mem_q[idx].data;
      end
    end
  end
`endif

endmodule

// File: rtl/reg_writeback.sv
// Serialises load returns and queued ALU results into one bank write per cycle
// and tracks pending loads per register. WB_FWD_EN adds a forwarding lookup.
module reg_writeback
  import wb_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input logic            clk,
  input logic            reset,
  reg_writeback_if.slave bus
);

  wb_entry_t         pushEntry;
  wb_entry_t         fifoHead;
  logic              fifoFull;
  logic              fifoEmpty;
  logic [AW:0]       unusedFifoCount;
  logic              fifoPush;
  logic              fifoPop;

  logic              wbEn_q,      wbEn_d;
  logic [REG_W-1:0]  wbDest_q,    wbDest_d;
  logic [DATA_W-1:0] wbData_q,    wbData_d;
  logic [NREGS-1:0]  busy_q,      busy_d;
  logic              issueErr_q,  issueErr_d;

`ifdef WB_FWD_EN
  logic              srchHit;
  logic [DATA_W-1:0] srchData;
`endif

  assign pushEntry     = '{dest: bus.alu_dest, data: bus.alu_data};
  assign bus.alu_ready = !fifoFull;
  assign fifoPush      = bus.alu_valid && !fifoFull;
  assign fifoPop       = !bus.ld_valid && !fifoEmpty;

  wb_fifo #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push_i      (fifoPush),
    .pushEntry_i (pushEntry),
    .pop_i       (fifoPop),
    .head_o      (fifoHead),
    .full_o      (fifoFull),
    .empty_o     (fifoEmpty),
    .count_o     (unusedFifoCount)
`ifdef WB_FWD_EN
    ,
    .srchDest_i  (bus.fwd_src),
    .srchHit_o   (srchHit),
    .srchData_o  (srchData)
`endif
  );

  // Loads own the write slot; an idle slot keeps dest/data at their last values.
  always_comb begin
    wbEn_d   = 1'b0;
    wbDest_d = wbDest_q;
    wbData_d = wbData_q;
    if (bus.ld_valid) begin
      wbEn_d   = 1'b1;
      wbDest_d = bus.ld_dest;
      wbData_d = bus.ld_data;
    end else if (!fifoEmpty) begin
      wbEn_d   = 1'b1;
      wbDest_d = fifoHead.dest;
      wbData_d = fifoHead.data;
    end
  end

  // Clear before set so a back-to-back load to the same register stays busy.
  always_comb begin
    busy_d = busy_q;
    if (bus.ld_valid) busy_d[bus.ld_dest] = 1'b0;
    if (bus.ld_issue) busy_d[bus.ld_issue_dest] = 1'b1;
    issueErr_d = issueErr_q |
                 (bus.ld_issue && busy_q[bus.ld_issue_dest] &&
                  !(bus.ld_valid && (bus.ld_dest == bus.ld_issue_dest)));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wbEn_q     <= 1'b0;
      wbDest_q   <= '0;
      wbData_q   <= '0;
      busy_q     <= '0;
      issueErr_q <= 1'b0;
    end else begin
      wbEn_q     <= wbEn_d;
      wbDest_q   <= wbDest_d;
      wbData_q   <= wbData_d;
      busy_q     <= busy_d;
      issueErr_q <= issueErr_d;
    end
  end

  assign bus.wb_en     = wbEn_q;
  assign bus.wb_dest   = wbDest_q;
  assign bus.wb_data   = wbData_q;
  assign bus.busy      = busy_q;
  assign bus.issue_err = issueErr_q;

`ifdef WB_FWD_EN
  always_comb begin
    bus.fwd_hit  = 1'b0;
    bus.fwd_data = '0;
    if (bus.ld_valid && (bus.ld_dest == bus.fwd_src)) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = bus.ld_data;
    end else if (srchHit) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = srchData;
    end else if (wbEn_q && (wbDest_q == bus.fwd_src)) begin
      bus.fwd_hit  = 1'b1;
      bus.fwd_data = wbData_q;
    end
  end
`endif

endmodule

// File: tb/tb_reg_writeback.sv
// Directed bench for reg_writeback with a write-order scoreboard; covers the
// forwarding port when WB_FWD_EN is defined.
module tb_reg_writeback;
  import wb_pkg::*;

  logic clk;
  logic reset;
  int   compared;
  int   mismatched;

  reg_writeback_if bus ();

  reg_writeback #(.DEPTH(4), .AW(2)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    compared++;
    assert (observed === expected)
    else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic aluValid, input logic [3:0] aluDest,
                               input logic [31:0] aluData, input logic ldIssue,
                               input logic [3:0] ldIssueDest, input logic ldValid,
                               input logic [3:0] ldDest, input logic [31:0] ldData);
    bus.alu_valid     = aluValid;
    bus.alu_dest      = aluDest;
    bus.alu_data      = aluData;
    bus.ld_issue      = ldIssue;
    bus.ld_issue_dest = ldIssueDest;
    bus.ld_valid      = ldValid;
    bus.ld_dest       = ldDest;
    bus.ld_data       = ldData;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: accepted ALU entries queue up; a load seen before an edge
  // claims that edge's write, otherwise the oldest queued ALU entry does.
  wb_entry_t   aluQ[$];
  logic        prevLd;
  wb_entry_t   prevLdEntry;
  logic        prevPush;
  wb_entry_t   prevAluEntry;
  logic [3:0]  lastDest;
  logic [31:0] lastData;

  always @(negedge clk) begin
    logic        expEn;
    logic [3:0]  expDest;
    logic [31:0] expData;
    wb_entry_t   e;
    if (reset) begin
      aluQ.delete();
      prevLd   = 1'b0;
      prevPush = 1'b0;
      lastDest = '0;
      lastData = '0;
      checkOutput("rstWbEn", {31'd0, bus.wb_en}, 32'd0);
    end else begin
      expEn   = 1'b0;
      expDest = lastDest;
      expData = lastData;
      if (prevLd) begin
        expEn   = 1'b1;
        expDest = prevLdEntry.dest;
        expData = prevLdEntry.data;
      end else if (aluQ.size() > 0) begin
        e       = aluQ.pop_front();
        expEn   = 1'b1;
        expDest = e.dest;
        expData = e.data;
      end
      checkOutput("sbWbEn",   {31'd0, bus.wb_en},   {31'd0, expEn});
      checkOutput("sbWbDest", {28'd0, bus.wb_dest}, {28'd0, expDest});
      checkOutput("sbWbData", bus.wb_data, expData);
      lastDest = expDest;
      lastData = expData;
      if (prevPush) aluQ.push_back(prevAluEntry);
      checkOutput("sbAluReady", {31'd0, bus.alu_ready}, {31'd0, (aluQ.size() < 4)});
      prevLd       = bus.ld_valid;
      prevLdEntry  = '{dest: bus.ld_dest, data: bus.ld_data};
      prevPush     = bus.alu_valid && (aluQ.size() < 4);
      prevAluEntry = '{dest: bus.alu_dest, data: bus.alu_data};
    end
  end

  initial begin
    compared   = 0;
    mismatched = 0;
    reset      = 1'b1;
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
`ifdef WB_FWD_EN
    bus.fwd_src = '0;
`endif
    #1;
    checkOutput("resetWbEn",     {31'd0, bus.wb_en},     32'd0);
    checkOutput("resetWbDest",   {28'd0, bus.wb_dest},   32'd0);
    checkOutput("resetWbData",   bus.wb_data,            32'd0);
    checkOutput("resetBusy",     {16'd0, bus.busy},      32'd0);
    checkOutput("resetIssueErr", {31'd0, bus.issue_err}, 32'd0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    checkOutput("readyAfterReset", {31'd0, bus.alu_ready}, 32'd1);

    // Single uncontended ALU result reaches the bank two edges after acceptance.
    applyStimulus(1, 4'd3, 32'h0000_00AA, 0, 0, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("aluEdge1WbEn", {31'd0, bus.wb_en}, 32'd0);
    tick();
    checkOutput("aluEdge2WbEn",   {31'd0, bus.wb_en},   32'd1);
    checkOutput("aluEdge2WbDest", {28'd0, bus.wb_dest}, 32'd3);
    checkOutput("aluEdge2WbData", bus.wb_data,          32'h0000_00AA);
    tick();
    checkOutput("aluEdge3WbEn",   {31'd0, bus.wb_en},   32'd0);
    checkOutput("aluEdge3Hold",   bus.wb_data,          32'h0000_00AA);

    // Loads hog the slot for six cycles while four ALU results fill the FIFO.
    for (int i = 0; i < 6; i++) begin
      if (i == 4) checkOutput("fullNotReady", {31'd0, bus.alu_ready}, 32'd0);
      if (i < 4)
        applyStimulus(1, 4'(i + 1), 32'h11 * (i + 1), 0, 0, 1, 4'(i + 8), 32'h100 + i);
      else
        applyStimulus(0, 0, 0, 0, 0, 1, 4'(i + 8), 32'h100 + i);
      tick();
      checkOutput("loadFirstDest", {28'd0, bus.wb_dest}, i + 8);
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      checkOutput("drainDest", {28'd0, bus.wb_dest}, i + 1);
      checkOutput("drainData", bus.wb_data, 32'h11 * (i + 1));
    end
    tick();
    checkOutput("drainDoneWbEn", {31'd0, bus.wb_en}, 32'd0);

    // Load to r5 is busy until its data returns three cycles later.
    applyStimulus(0, 0, 0, 1, 4'd5, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy5Gap0", {31'd0, bus.busy[5]}, 32'd1);
    tick();
    checkOutput("busy5Gap1", {31'd0, bus.busy[5]}, 32'd1);
    tick();
    checkOutput("busy5Gap2", {31'd0, bus.busy[5]}, 32'd1);
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd5, 32'h1234);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("busy5Clear",  {16'd0, bus.busy},    32'd0);
    checkOutput("ld5WbDest",   {28'd0, bus.wb_dest}, 32'd5);
    checkOutput("ld5WbData",   bus.wb_data,          32'h1234);

    // Back-to-back load to r7: set wins, no error; a true double issue errs.
    applyStimulus(0, 0, 0, 1, 4'd7, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 1, 4'd7, 1, 4'd7, 32'h77);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("b2bBusy7",     {31'd0, bus.busy[7]},   32'd1);
    checkOutput("b2bIssueErr",  {31'd0, bus.issue_err}, 32'd0);
    applyStimulus(0, 0, 0, 1, 4'd7, 0, 0, 0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd7, 32'h78);
    checkOutput("dupIssueErr",  {31'd0, bus.issue_err}, 32'd1);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    checkOutput("stickyIssueErr", {31'd0, bus.issue_err}, 32'd1);
    checkOutput("busyAfterR7",    {16'd0, bus.busy},      32'd0);

    // Mid-operation reset with three queued entries and r0/r5 pending.
    applyStimulus(1, 4'd1, 32'hA1, 1, 4'd0, 1, 4'd12, 32'hC0);
    tick();
    applyStimulus(1, 4'd2, 32'hA2, 1, 4'd5, 1, 4'd12, 32'hC1);
    tick();
    applyStimulus(1, 4'd3, 32'hA3, 0, 0, 1, 4'd12, 32'hC2);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("preRstBusy", {16'd0, bus.busy},  32'h0021);
    checkOutput("preRstWbEn", {31'd0, bus.wb_en}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstWbEn",     {31'd0, bus.wb_en},     32'd0);
    checkOutput("asyncRstBusy",     {16'd0, bus.busy},      32'd0);
    checkOutput("asyncRstIssueErr", {31'd0, bus.issue_err}, 32'd0);
    checkOutput("asyncRstReady",    {31'd0, bus.alu_ready}, 32'd1);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("noStaleWbEn", {31'd0, bus.wb_en}, 32'd0);
    end

`ifdef WB_FWD_EN
    // Youngest FIFO match beats older, and an in-flight load beats both.
    applyStimulus(1, 4'd2, 32'h10, 0, 0, 1, 4'd9, 32'h99);
    tick();
    applyStimulus(1, 4'd2, 32'h20, 0, 0, 1, 4'd9, 32'h99);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 1, 4'd9, 32'h99);
    bus.fwd_src = 4'd2;
    #1;
    checkOutput("fwdFifoHit",  {31'd0, bus.fwd_hit}, 32'd1);
    checkOutput("fwdFifoData", bus.fwd_data,         32'h20);
    bus.ld_dest = 4'd2;
    bus.ld_data = 32'h30;
    #1;
    checkOutput("fwdLoadHit",  {31'd0, bus.fwd_hit}, 32'd1);
    checkOutput("fwdLoadData", bus.fwd_data,         32'h30);
    bus.fwd_src = 4'd15;
    #1;
    checkOutput("fwdMissHit",  {31'd0, bus.fwd_hit}, 32'd0);
    checkOutput("fwdMissData", bus.fwd_data,         32'd0);
    tick();
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) tick();
`endif

    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
